// File: rtl/password_store_arbiter.sv
// Single-port arbiter for the password store: setter writes, validator reads, plus a
// clear engine that is only built when PASSWORD_ARBITER_CLEAR_EN is defined.
module password_store_arbiter #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lockDown,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrGnt,
  output logic              wrDenied,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              rdGnt,
  output logic              rdValid,
  output logic [DATA_W-1:0] rdData,
  input  logic              clearReq,
  output logic              clearBusy,
  output logic [ADDR_W-1:0] storeAddress,
  output logic              storeWrite,
  output logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] storeQ,
  output logic [1:0]        dbgState
);

`ifdef PASSWORD_ARBITER_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_CLEAR = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_wr_q, last_wr_d;    // 1: most recent grant went to the writer
  logic              clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, rd_hold_q, rd_hold_d;
  logic              rd_valid_q, rd_valid_d, wr_denied_q, wr_denied_d;
  logic              rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d, busy_q, busy_d;
  logic              st_we_q, st_we_d;
  logic [ADDR_W-1:0] st_addr_q, st_addr_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;
  logic              wr_pend, rd_pend, clr_go;

  always_comb begin
    wr_pend    = wrReq & ~lockDown;
    rd_pend    = rdReq;
    clr_go     = CLR_EN & (clr_pend_q | clearReq);
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_wr_d  = last_wr_q;
    clr_pend_d = clr_pend_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (clr_go)                  state_d = S_CLEAR;
        else if (rd_pend && wr_pend) state_d = last_wr_q ? S_READ : S_WRITE;
        else if (rd_pend)            state_d = S_READ;
        else if (wr_pend)            state_d = S_WRITE;
      end
      // the owner's own request is ignored here, so a lone requester idles in between
      S_READ: begin
        last_wr_d = 1'b0;
        if (clr_go)       state_d = S_CLEAR;
        else if (wr_pend) state_d = S_WRITE;
        else              state_d = S_IDLE;
      end
      S_WRITE: begin
        last_wr_d = 1'b1;
        if (clr_go)       state_d = S_CLEAR;
        else if (rd_pend) state_d = S_READ;
        else              state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_CLEAR) begin
      if (state_d == S_CLEAR) clr_pend_d = 1'b0;
      else if (clearReq)      clr_pend_d = CLR_EN;
    end

    if (state_d == S_READ && state_q != S_READ) rd_addr_d = rdAddr;
    if (state_d == S_WRITE && state_q != S_WRITE) begin
      wr_addr_d = wrAddr;
      wr_data_d = wrData;
    end

    rd_valid_d  = (state_q == S_READ);
    rd_hold_d   = rd_valid_q ? storeQ : rd_hold_q;
    wr_denied_d = (state_q == S_IDLE) & wrReq & lockDown;

    rd_gnt_d = (state_d == S_READ);
    wr_gnt_d = (state_d == S_WRITE);
    busy_d   = (state_d == S_CLEAR);
    st_we_d  = wr_gnt_d | busy_d;
    case (state_d)
      S_READ:  st_addr_d = rd_addr_d;
      S_WRITE: st_addr_d = wr_addr_d;
      S_CLEAR: st_addr_d = cnt_d;
      default: st_addr_d = '0;
    endcase
    st_data_d = wr_gnt_d ? wr_data_d : '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      last_wr_q   <= 1'b1;
      clr_pend_q  <= 1'b0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_hold_q   <= '0;
      rd_valid_q  <= 1'b0;
      wr_denied_q <= 1'b0;
      rd_gnt_q    <= 1'b0;
      wr_gnt_q    <= 1'b0;
      busy_q      <= 1'b0;
      st_we_q     <= 1'b0;
      st_addr_q   <= '0;
      st_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      clr_pend_q  <= clr_pend_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_hold_q   <= rd_hold_d;
      rd_valid_q  <= rd_valid_d;
      wr_denied_q <= wr_denied_d;
      rd_gnt_q    <= rd_gnt_d;
      wr_gnt_q    <= wr_gnt_d;
      busy_q      <= busy_d;
      st_we_q     <= st_we_d;
      st_addr_q   <= st_addr_d;
      st_data_q   <= st_data_d;
    end
  end

  // store read data arrives the cycle after the address, so it is passed straight
  // through on the valid cycle and held afterwards
  assign rdData       = rd_valid_q ? storeQ : rd_hold_q;
  assign rdValid      = rd_valid_q;
  assign rdGnt        = rd_gnt_q;
  assign wrGnt        = wr_gnt_q;
  assign wrDenied     = wr_denied_q;
  assign clearBusy    = busy_q;
  assign storeAddress = st_addr_q;
  assign storeWrite   = st_we_q;
  assign storeData    = st_data_q;
  assign dbgState     = state_q;

endmodule

// File: tb/tb_password_store_arbiter.sv
// Bench for password_store_arbiter: a synchronous store model plus a cycle-level
// reference of the arbitration rules, directed scenarios and a random run.
module tb_password_store_arbiter;
`ifdef PASSWORD_ARBITER_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       lockDown = 1'b0, wrReq = 1'b0, rdReq = 1'b0, clearReq = 1'b0;
  logic [1:0] wrAddr = '0, rdAddr = '0;
  logic [3:0] wrData = '0;
  logic       wrGnt, wrDenied, rdGnt, rdValid, clearBusy, storeWrite;
  logic [3:0] rdData, storeData;
  logic [1:0] storeAddress, dbgState;
  logic [3:0] storeQ = '0;

  logic [3:0] smem [4] = '{4'h3, 4'h9, 4'h7, 4'hC};
  logic [3:0] gmem [4] = '{4'h3, 4'h9, 4'h7, 4'hC};

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int         m_st, m_cnt;
  bit         m_last_wr, m_clr_pend, m_rdv, m_den;
  logic [1:0] m_ra, m_wa;
  logic [3:0] m_wd, m_rdd;

  password_store_arbiter #(.DEPTH(4), .ADDR_W(2), .DATA_W(4)) dut (
    .CLK(CLK), .RST(RST), .lockDown(lockDown),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGnt(wrGnt), .wrDenied(wrDenied),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdGnt(rdGnt), .rdValid(rdValid), .rdData(rdData),
    .clearReq(clearReq), .clearBusy(clearBusy),
    .storeAddress(storeAddress), .storeWrite(storeWrite), .storeData(storeData),
    .storeQ(storeQ), .dbgState(dbgState)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (storeWrite) smem[storeAddress] <= storeData;
    storeQ <= smem[storeAddress];
  end

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_last_wr = 1'b1; m_clr_pend = 1'b0;
    m_rdv = 1'b0; m_den = 1'b0; m_ra = '0; m_wa = '0; m_wd = '0; m_rdd = '0;
  endtask

  // Apply one clock: the model consumes the inputs seen at the edge, then the
  // bench waits for the edge and steps 1 time unit past it.
  task automatic tick();
    int  ns;
    bit  wp, rp, clr;
    m_rdv = (m_st == 1);
    if (m_st == 1) m_rdd = gmem[m_ra];
    if (m_st == 2) gmem[m_wa] = m_wd;
    if (m_st == 3) gmem[m_cnt] = 4'h0;
    m_den = (m_st == 0) && wrReq && lockDown;
    wp  = wrReq && !lockDown;
    rp  = rdReq;
    clr = CLR && (m_st != 3) && (m_clr_pend || clearReq);
    if (m_st == 3) begin
      ns    = (m_cnt == 3) ? 0 : 3;
      m_cnt = (m_cnt == 3) ? 0 : m_cnt + 1;
    end else if (clr) ns = 3;
    else if (m_st == 0) ns = (rp && wp) ? (m_last_wr ? 1 : 2) : (rp ? 1 : (wp ? 2 : 0));
    else if (m_st == 1) ns = wp ? 2 : 0;
    else                ns = rp ? 1 : 0;
    if (m_st != 3 && clearReq && CLR) m_clr_pend = 1'b1;
    if (ns == 3 && m_st != 3) m_clr_pend = 1'b0;
    if (ns == 1 && m_st != 1) m_ra = rdAddr;
    if (ns == 2 && m_st != 2) begin m_wa = wrAddr; m_wd = wrData; end
    if (m_st == 1) m_last_wr = 1'b0;
    if (m_st == 2) m_last_wr = 1'b1;
    m_st = ns;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [17:0] exp_bus();
    logic [1:0] a;
    logic [3:0] d;
    a = (m_st == 1) ? m_ra : (m_st == 2) ? m_wa : (m_st == 3) ? 2'(m_cnt) : 2'd0;
    d = (m_st == 2) ? m_wd : 4'd0;
    return {2'(m_st), m_st == 1, m_st == 2, m_den, m_rdv, m_rdd, m_st == 3, a, m_st >= 2, d};
  endfunction

  function automatic logic [17:0] act_bus();
    return {dbgState, rdGnt, wrGnt, wrDenied, rdValid, rdData, clearBusy,
            storeAddress, storeWrite, storeData};
  endfunction

  task automatic apply_reset();
    RST = 1'b0; rdReq = 0; wrReq = 0; clearReq = 0; lockDown = 0;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b1;
    model_reset();
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    wrAddr = a; wrData = d; wrReq = 1'b1; tick();
    wrReq = 1'b0; tick();
  endtask

  task automatic do_read(input logic [1:0] a);
    rdAddr = a; rdReq = 1'b1; tick();
    rdReq = 1'b0; tick();
  endtask

  task automatic test_reset();
    @(posedge CLK); @(posedge CLK); #1;
    n_vec++;
    if (act_bus() !== 18'h0) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", act_bus(), 18'h0);
    end
    RST = 1'b1;
    model_reset();
  endtask

  task automatic test_read_basic();
    rdAddr = 2'd2; rdReq = 1'b1; tick();
    n_vec++;
    if ({rdGnt, storeAddress, storeWrite} !== {1'b1, 2'd2, 1'b0}) begin
      n_err++; $display("FAIL read_gnt: got %b want %b", {rdGnt, storeAddress, storeWrite}, 4'b1100);
    end
    rdReq = 1'b0; tick();
    n_vec++;
    if ({rdValid, rdData} !== {1'b1, 4'h7}) begin
      n_err++; $display("FAIL read_data: got %h want %h", {rdValid, rdData}, 5'h17);
    end
    tick();
    n_vec++;
    if ({rdValid, rdData} !== {1'b0, 4'h7} || act_bus() !== exp_bus()) begin
      n_err++; $display("FAIL read_hold: got %h want %h", act_bus(), exp_bus());
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rdAddr = 2'd1; wrAddr = 2'd3; wrData = 4'($urandom_range(0, 15));
    rdReq = 1'b1; wrReq = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_vec++;
      if ({rdGnt, wrGnt} !== {i % 2 == 1, i % 2 == 0} || act_bus() !== exp_bus()) begin
        n_err++;
        $display("FAIL alternate cycle %0d: got rg/wg=%b%b bus %h want bus %h",
                 i, rdGnt, wrGnt, act_bus(), exp_bus());
      end
    end
    rdReq = 1'b0; wrReq = 1'b0;
    tick(); tick();
  endtask

  task automatic test_lockdown();
    lockDown = 1'b1; wrAddr = 2'd1; wrData = 4'd5; wrReq = 1'b1;
    tick();
    n_vec++;
    if ({wrDenied, wrGnt, storeWrite} !== 3'b100) begin
      n_err++; $display("FAIL lock_deny: got %b want 100", {wrDenied, wrGnt, storeWrite});
    end
    wrReq = 1'b0;
    tick();
    n_vec++;
    if ({wrDenied, wrGnt, storeWrite} !== 3'b000) begin
      n_err++; $display("FAIL lock_pulse: got %b want 000", {wrDenied, wrGnt, storeWrite});
    end
    lockDown = 1'b0;
    do_read(2'd1);
    n_vec++;
    if ({rdValid, rdData} !== {1'b1, 4'h9} || act_bus() !== exp_bus()) begin
      n_err++; $display("FAIL lock_entry1: got %h want %h", {rdValid, rdData}, 5'h19);
    end
  endtask

  task automatic test_clear();
`ifdef PASSWORD_ARBITER_CLEAR_EN
    clearReq = 1'b1; rdAddr = 2'd2; rdReq = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      clearReq = 1'b0;
      n_vec++;
      if (i <= 4 && {clearBusy, storeWrite, storeAddress, storeData, rdGnt} !==
                    {1'b1, 1'b1, 2'(i - 1), 4'h0, 1'b0}) begin
        n_err++; $display("FAIL clear_cycle %0d: got %h want %h", i, act_bus(), exp_bus());
      end else if (i > 4 && {clearBusy, rdGnt} !== {1'b0, i == 6}) begin
        n_err++; $display("FAIL clear_after %0d: got busy/gnt %b%b", i, clearBusy, rdGnt);
      end
    end
    rdReq = 1'b0;
    tick();
    n_vec++;
    if ({rdValid, rdData} !== {1'b1, 4'h0} || act_bus() !== exp_bus()) begin
      n_err++; $display("FAIL clear_read: got %h want %h", act_bus(), exp_bus());
    end
`else
    clearReq = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      clearReq = 1'b0;
      n_vec++;
      if ({clearBusy, storeWrite} !== 2'b00 || act_bus() !== exp_bus()) begin
        n_err++; $display("FAIL noclear cycle %0d: got %h want %h", i, act_bus(), exp_bus());
      end
    end
`endif
  endtask

`ifdef PASSWORD_ARBITER_CLEAR_EN
  task automatic test_reset_midclear();
    logic [3:0] v [4];
    logic [3:0] want;
    for (int i = 0; i < 4; i++) begin
      v[i] = 4'($urandom_range(1, 15));
      do_write(2'(i), v[i]);
    end
    clearReq = 1'b1; tick();
    clearReq = 1'b0; tick();
    #2 RST = 1'b0;
    #1;
    n_vec++;
    if (act_bus() !== 18'h0) begin
      n_err++; $display("FAIL midclear_reset: got %h want %h", act_bus(), 18'h0);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      do_read(2'(i));
      want = (i == 0) ? 4'h0 : v[i];
      n_vec++;
      if ({rdValid, rdData} !== {1'b1, want} || act_bus() !== exp_bus()) begin
        n_err++; $display("FAIL midclear_entry%0d: got %h want %h", i, rdData, want);
      end
    end
  endtask
`endif

  task automatic test_reset_during_read();
    rdAddr = 2'd0; rdReq = 1'b1; tick();
    rdReq = 1'b0;
    #2 RST = 1'b0;
    #1;
    n_vec++;
    if ({rdGnt, storeAddress, storeWrite} !== 4'b0) begin
      n_err++; $display("FAIL rdreset_gnt: got %b want 0000", {rdGnt, storeAddress, storeWrite});
    end
    @(posedge CLK); #1;
    n_vec++;
    if (rdValid !== 1'b0) begin
      n_err++; $display("FAIL rdreset_valid: got %b want 0", rdValid);
    end
    RST = 1'b1;
    model_reset();
    tick();
    n_vec++;
    if (act_bus() !== exp_bus()) begin
      n_err++; $display("FAIL rdreset_after: got %h want %h", act_bus(), exp_bus());
    end
  endtask

  task automatic test_random();
    bit nr, nw;
    for (int c = 0; c < 400; c++) begin
      nr = ($urandom_range(0, 2) != 0);
      nw = ($urandom_range(0, 2) != 0);
      if (!(rdReq && nr)) rdAddr = 2'($urandom_range(0, 3));
      if (!(wrReq && nw)) begin
        wrAddr = 2'($urandom_range(0, 3));
        wrData = 4'($urandom_range(0, 15));
      end
      rdReq    = nr;
      wrReq    = nw;
      lockDown = ($urandom_range(0, 3) == 0);
      clearReq = ($urandom_range(0, 19) == 0);
      tick();
      n_vec++;
      if (act_bus() !== exp_bus()) begin
        n_err++; $display("FAIL random cycle %0d: got %h want %h", c, act_bus(), exp_bus());
      end
    end
    rdReq = 0; wrReq = 0; lockDown = 0; clearReq = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_lockdown();
    test_clear();
`ifdef PASSWORD_ARBITER_CLEAR_EN
    test_reset_midclear();
`endif
    test_reset_during_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/password_store_arbiter.md
# password_store_arbiter

Arbitrates single-port access to the 4-entry password store among the password setter (write requester), the password validator (read requester) and an internal clear engine. Sits between the requesters and the store and is the only block driving store address/write/data. Uses level request / one-cycle grant handshakes with round-robin fairness between read and write. Blocks writes while lockdown is active.

## Interface
- DEPTH, 4, number of store entries
- ADDR_W, 2, store address width (clog2(DEPTH))
- DATA_W, 4, digit width
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- lockDown  in  1  write inhibit from validator
- wrReq / wrAddr / wrData  in  1 / ADDR_W / DATA_W  setter write request, address, data
- wrGnt  out  1  write performed this cycle
- wrDenied  out  1  one-cycle pulse: write request refused by lockdown
- rdReq / rdAddr  in  1 / ADDR_W  validator read request, address
- rdGnt  out  1  read address presented to store this cycle
- rdValid / rdData  out  1 / DATA_W  read data valid pulse, read data
- clearReq  in  1  pulse: zero every store entry
- clearBusy  out  1  clear sequence in progress
- storeAddress / storeWrite / storeData  out  ADDR_W / 1 / DATA_W  store port
- storeQ  in  DATA_W  store read data, valid one cycle after address
- dbgState  out  2  current FSM state

## Operation
- States: S_IDLE=0, S_READ=1, S_WRITE=2, S_CLEAR=3.
- Write pending = wrReq & !lockDown. Read pending = rdReq.
- S_IDLE, in priority order: clearPending → S_CLEAR; read pending only → S_READ; write pending only → S_WRITE; both pending → the one not equal to lastOwner.
- wrReq & lockDown while in S_IDLE → wrDenied pulses the next cycle. No grant is issued.
- S_READ: rdGnt=1, storeAddress=latched rdAddr, storeWrite=0. lastOwner←read.
- S_WRITE: wrGnt=1, storeAddress/storeData=latched wrAddr/wrData, storeWrite=1. lastOwner←write.
  - The write completes even if lockDown rises during this cycle.
- Exit from S_READ/S_WRITE: clearPending → S_CLEAR; else the other requester pending → its grant state; else S_IDLE.
  - The current owner's req is not sampled in its own grant cycle.
  - An owner must drop req by the cycle after gnt unless it wants another access.
- Address/data are latched at the transition into the grant state. Requesters hold them stable while req is high.
- clearPending:
  - Set by clearReq in any state except S_CLEAR. clearReq in S_CLEAR is ignored.
  - Cleared on entry to S_CLEAR.
- S_CLEAR:
  - Counter runs 0..DEPTH-1 with storeWrite=1, storeData=0, one entry per cycle.
  - Exits to S_IDLE after address DEPTH-1.
  - Ignores lockDown. rd/wr requests stay pending, as levels, until it finishes.
- Outside grant/clear states: storeAddress=0, storeWrite=0, storeData=0.

## Timing
- Reset values: state S_IDLE, lastOwner=write (so a tie after reset grants read first), clearPending=0, counter=0. All outputs 0, including rdData.
- Read latency: rdReq sampled at edge N → rdGnt high in cycle N+1 → rdValid pulse with rdData=storeQ in cycle N+2. rdData holds until the next rdValid.
- Write latency: wrReq sampled at edge N → wrGnt and store write in cycle N+1.
- Back-to-back alternating read/write: one access per cycle. A single requester alone gets at most one access per 2 cycles.
- Clear: clearReq at edge N in S_IDLE → clearBusy high cycles N+1..N+DEPTH. Writes addresses 0,1,2,3 in order.
- Clear when pending clear and a request coincide: clear wins. The request is granted in the cycle after clearBusy falls.
- Asynchronous reset mid-clear aborts the sequence; already-zeroed entries stay zeroed. Reset during S_READ suppresses rdValid.

## Configuration
- PASSWORD_ARBITER_CLEAR_EN defined: clear engine, clearPending and S_CLEAR are present as described.
- Not defined:
  - clearReq is ignored and clearBusy is tied 0.
  - S_CLEAR is unreachable; arbitration uses read/write only.

## Test plan
- Reset, rdReq=1 rdAddr=2 for one cycle, store holds 7 at address 2 → rdGnt in cycle 1, rdValid=1 rdData=7 in cycle 2.
- wrReq and rdReq both held high from reset → grants alternate R,W,R,W on consecutive cycles, never two writes in a row.
- lockDown=1, wrReq=1 wrAddr=1 wrData=5 → wrDenied pulse, no storeWrite. Entry 1 unchanged on a later read.
- clearReq pulse with rdReq pending → storeWrite=1 data 0 at addresses 0..3 over 4 cycles with clearBusy=1. Then rdGnt, and the read returns 0.
- RST low during the second clear cycle → all outputs 0 immediately. Entry 0 reads 0, entries 2..3 keep prior values.
- Build without PASSWORD_ARBITER_CLEAR_EN, pulse clearReq → clearBusy stays 0 and no store writes occur.
